// File: rtl/divider_core.sv
// divider_core: iterative restoring divider for DIV/IDIV.
// It produces one quotient bit per clock. Magnitudes are divided unsigned,
// and the signs are applied afterwards in FIXUP.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   start           - launch pulse; accepted only when busy=0
//   is_8_bit        - 1: dividend[15:0] / divisor[7:0]; 0: dividend[31:0] / divisor[15:0]
//   is_signed       - 1: IDIV (two's complement), 0: DIV
//   dividend        - DX:AX, or AX in 8-bit mode
//   divisor         - divisor operand
//   quotient        - result; upper half is zero in 8-bit mode
//   remainder       - result; takes the sign of the dividend
//   divide_error    - zero divisor or quotient overflow; valid with complete
//   busy            - high while in INIT, DIVIDE or FIXUP
//   complete        - one-cycle pulse when the results are valid
module divider_core #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_8_bit,
  input  logic                 is_signed,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 divide_error,
  output logic                 busy,
  output logic                 complete
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned HW = WIDTH / 2;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] LIM_8  = WIDTH'(1) << (HW - 1);
  localparam logic [WIDTH-1:0] LIM_16 = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [2:0] {IDLE, INIT, DIVIDE, FIXUP, DONE} state_t;

  state_t            state;
  logic              op_8;
  logic              op_signed;
  logic [DW-1:0]     op_dividend;
  logic [WIDTH-1:0]  op_divisor;
  logic              q_neg;
  logic              r_neg;
  logic [WIDTH-1:0]  b_reg;
  logic [WIDTH-1:0]  lo_sr;   // remaining low dividend bits, MSB first
  logic [WIDTH-1:0]  q_sr;
  logic [WIDTH-1:0]  pr;      // partial remainder, always < divisor
  logic [CW-1:0]     count;

  // INIT: operand magnitudes, split of the dividend, and the early error check
  logic              a_sign_c;
  logic              b_sign_c;
  logic [WIDTH-1:0]  a16_c;
  logic [DW-1:0]     a32_c;
  logic [HW-1:0]     b8_c;
  logic [WIDTH-1:0]  b16_c;
  logic [WIDTH-1:0]  b_mag_c;
  logic [WIDTH-1:0]  hi_c;
  logic [WIDTH-1:0]  lo_c;
  logic              init_err_c;

  always_comb begin
    a_sign_c   = 1'b0;
    b_sign_c   = 1'b0;
    a16_c      = op_dividend[WIDTH-1:0];
    a32_c      = op_dividend;
    b8_c       = op_divisor[HW-1:0];
    b16_c      = op_divisor;
    b_mag_c    = '0;
    hi_c       = '0;
    lo_c       = '0;
    if (op_8) begin
      a_sign_c = op_signed & op_dividend[WIDTH-1];
      b_sign_c = op_signed & op_divisor[HW-1];
      if (a_sign_c) a16_c = ~op_dividend[WIDTH-1:0] + WIDTH'(1);
      if (b_sign_c) b8_c  = ~op_divisor[HW-1:0] + HW'(1);
      b_mag_c  = {HW'(0), b8_c};
      hi_c     = {HW'(0), a16_c[WIDTH-1:HW]};
      // The low byte is left-aligned so the shift-out MSB serves both modes.
      lo_c     = {a16_c[HW-1:0], HW'(0)};
    end else begin
      a_sign_c = op_signed & op_dividend[DW-1];
      b_sign_c = op_signed & op_divisor[WIDTH-1];
      // The most-negative dividend negates to itself, which is exactly 2^31 when read unsigned.
      if (a_sign_c) a32_c = ~op_dividend + DW'(1);
      if (b_sign_c) b16_c = ~op_divisor + WIDTH'(1);
      b_mag_c  = b16_c;
      hi_c     = a32_c[DW-1:WIDTH];
      lo_c     = a32_c[WIDTH-1:0];
    end
    // Upper half >= divisor means the quotient cannot fit in N bits.
    init_err_c = (b_mag_c == '0) || (hi_c >= b_mag_c);
  end

  // DIVIDE: shift in the next dividend bit, then do the trial subtract
  logic [WIDTH:0] shifted_c;
  logic           fits_c;

  always_comb begin
    shifted_c = {pr, lo_sr[WIDTH-1]};
    fits_c    = shifted_c >= {1'b0, b_reg};
  end

  // FIXUP: apply the signs, mask to N bits, and check for signed overflow
  logic [WIDTH-1:0] q_signed_c;
  logic [WIDTH-1:0] r_signed_c;
  logic [WIDTH-1:0] q_fix_c;
  logic [WIDTH-1:0] r_fix_c;
  logic             ovf_c;

  always_comb begin
    q_signed_c = q_neg ? (~q_sr + WIDTH'(1)) : q_sr;
    r_signed_c = r_neg ? (~pr + WIDTH'(1)) : pr;
    q_fix_c    = q_signed_c;
    r_fix_c    = r_signed_c;
    ovf_c      = 1'b0;
    if (op_8) begin
      q_fix_c = {HW'(0), q_signed_c[HW-1:0]};
      r_fix_c = {HW'(0), r_signed_c[HW-1:0]};
      ovf_c   = op_signed && (q_sr >= LIM_8);
    end else begin
      ovf_c   = op_signed && (q_sr >= LIM_16);
    end
  end

  // Control FSM and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      complete     <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      divide_error <= 1'b0;
      op_8         <= 1'b0;
      op_signed    <= 1'b0;
      op_dividend  <= '0;
      op_divisor   <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      b_reg        <= '0;
      lo_sr        <= '0;
      q_sr         <= '0;
      pr           <= '0;
      count        <= '0;
    end else begin
      complete <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            op_8        <= is_8_bit;
            op_signed   <= is_signed;
            op_dividend <= dividend;
            op_divisor  <= divisor;
            busy        <= 1'b1;
            state       <= INIT;
          end else begin
            state <= IDLE;
          end
        end
        INIT: begin
          if (init_err_c) begin
            quotient     <= '0;
            remainder    <= '0;
            divide_error <= 1'b1;
            busy         <= 1'b0;
            complete     <= 1'b1;
            state        <= DONE;
          end else begin
            b_reg <= b_mag_c;
            pr    <= hi_c;
            lo_sr <= lo_c;
            q_sr  <= '0;
            q_neg <= a_sign_c ^ b_sign_c;
            r_neg <= a_sign_c;
            count <= op_8 ? CW'(HW - 1) : CW'(WIDTH - 1);
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          pr    <= fits_c ? WIDTH'(shifted_c - {1'b0, b_reg}) : shifted_c[WIDTH-1:0];
          q_sr  <= {q_sr[WIDTH-2:0], fits_c};
          lo_sr <= lo_sr << 1;
          if (count == '0) begin
            state <= FIXUP;
          end else begin
            count <= count - CW'(1);
          end
        end
        FIXUP: begin
          quotient     <= ovf_c ? '0 : q_fix_c;
          remainder    <= ovf_c ? '0 : r_fix_c;
          divide_error <= ovf_c;
          busy         <= 1'b0;
          complete     <= 1'b1;
          state        <= DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
